sdram_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 31 +++
 rtl/sdram_arb_tagq.sv | 52 +++++
 rtl/sdram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: port ids, address field layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

  // Port ids, also the value stored per command in the tag queue.
  localparam logic PORT_CAP  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  // Word address layout {row, bank, col}.
  localparam int COL_W   = 9;
  localparam int BANK_W  = 2;
  localparam int ROW_W   = 13;
  localparam int ADDR_W  = ROW_W + BANK_W + COL_W;
  localparam int DATA_W  = 16;

  // Row-affinity key is bank+row, i.e. everything above the column.
  localparam int KEY_LSB = COL_W;
  localparam int KEY_MSB = ADDR_W - 1;
  localparam int KEY_W   = ROW_W + BANK_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic logic [KEY_W-1:0] row_key(input logic [ADDR_W-1:0] addr);
    return addr[KEY_MSB:KEY_LSB];
  endfunction

endpackage

// File: rtl/sdram_arb_tagq.sv
// In-order FIFO of 1-bit port ids for outstanding SDRAM commands.
// Latency: push visible at dout the cycle after; pop takes effect next cycle.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
// Ports: push/din write side, pop/dout read side (dout = head), full/empty status.
module sdram_arb_tagq #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port round-robin SDRAM arbiter with row-affinity burst locking and in-order response routing.
// Latency: 1 idle cycle to grant, then combinational pass-through; responses routed 1 cycle after m_bvalid.
// Backpressure: owner's aready follows m_aready, and is forced low while TAG_DEPTH commands are outstanding.
// Ports: s0_* capture requester, s1_* host requester, m_* sdram side, r_bwe/r_bdata shared response
// payload qualified by s0_bvalid/s1_bvalid, err sticky flag for a response with no outstanding command.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_avalid,
  output logic              s0_aready,
  input  logic              s0_awe,
  input  logic [ADDR_W-1:0] s0_aaddr,
  input  logic [DATA_W-1:0] s0_adata,
  output logic              s0_bvalid,
  input  logic              s1_avalid,
  output logic              s1_aready,
  input  logic              s1_awe,
  input  logic [ADDR_W-1:0] s1_aaddr,
  input  logic [DATA_W-1:0] s1_adata,
  output logic              s1_bvalid,
  output logic              r_bwe,
  output logic [DATA_W-1:0] r_bdata,
  output logic              m_avalid,
  input  logic              m_aready,
  output logic              m_awe,
  output logic [ADDR_W-1:0] m_aaddr,
  output logic [DATA_W-1:0] m_adata,
  input  logic              m_bvalid,
  input  logic              m_bwe,
  input  logic [DATA_W-1:0] m_bdata,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state, state_nxt;
  logic              owner, owner_nxt;
  logic              rr, rr_nxt;
  logic [CNT_W-1:0]  burst_cnt, cnt_nxt;
  logic [KEY_W-1:0]  last_row, last_nxt;

  logic              own_vld, own_we, other_vld, rr_vld;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              accept;
  logic              tag_full, tag_empty, tag_head, tag_pop;

  assign own_vld   = (owner == PORT_HOST) ? s1_avalid : s0_avalid;
  assign own_we    = (owner == PORT_HOST) ? s1_awe    : s0_awe;
  assign own_addr  = (owner == PORT_HOST) ? s1_aaddr  : s0_aaddr;
  assign own_data  = (owner == PORT_HOST) ? s1_adata  : s0_adata;
  assign other_vld = (owner == PORT_HOST) ? s0_avalid : s1_avalid;
  assign rr_vld    = (rr == PORT_HOST)    ? s1_avalid : s0_avalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner     <= PORT_CAP;
      rr        <= PORT_CAP;
      burst_cnt <= '0;
      last_row  <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr        <= rr_nxt;
      burst_cnt <= cnt_nxt;
      last_row  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    cnt_nxt   = burst_cnt;
    last_nxt  = last_row;
    m_avalid  = 1'b0;
    m_awe     = 1'b0;
    m_aaddr   = '0;
    m_adata   = '0;
    s0_aready = 1'b0;
    s1_aready = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((s0_avalid || s1_avalid) && !tag_full) begin
          state_nxt = ST_OWN;
          owner_nxt = rr_vld ? rr : ~rr;
          cnt_nxt   = '0;
        end
      end
      ST_OWN: begin
        m_avalid  = own_vld && !tag_full;
        m_awe     = own_we;
        m_aaddr   = own_addr;
        m_adata   = own_data;
        s0_aready = (owner == PORT_CAP)  && m_aready && !tag_full;
        s1_aready = (owner == PORT_HOST) && m_aready && !tag_full;
        accept    = own_vld && m_aready && !tag_full;
        if (accept) begin
          cnt_nxt  = burst_cnt + 1'b1;
          last_nxt = row_key(own_addr);
        end
        // Give up the bus when the owner goes quiet, its burst quota is spent, or it is
        // stalled on a row change while the other port could use the bus instead.
        if (!own_vld
            || (accept && burst_cnt == CNT_W'(MAX_BURST - 1))
            || (other_vld && row_key(own_addr) != last_row && !accept)) begin
          state_nxt = ST_IDLE;
          rr_nxt    = ~owner;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sdram_arb_tagq #(.DEPTH(TAG_DEPTH)) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (owner),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign tag_pop = m_bvalid && !tag_empty;

  // Responses come back in acceptance order, so the queue head names the issuing port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_bvalid <= 1'b0;
      s1_bvalid <= 1'b0;
      r_bwe     <= 1'b0;
      r_bdata   <= '0;
      err       <= 1'b0;
    end else begin
      s0_bvalid <= tag_pop && (tag_head == PORT_CAP);
      s1_bvalid <= tag_pop && (tag_head == PORT_HOST);
      if (tag_pop) begin
        r_bwe   <= m_bwe;
        r_bdata <= m_bdata;
      end
      if (m_bvalid && tag_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int MB = 8;
  localparam int TD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_avalid = 1'b0, s0_awe = 1'b0;
  logic [23:0] s0_aaddr = '0;
  logic [15:0] s0_adata = '0;
  logic        s0_aready, s0_bvalid;
  logic        s1_avalid = 1'b0, s1_awe = 1'b0;
  logic [23:0] s1_aaddr = '0;
  logic [15:0] s1_adata = '0;
  logic        s1_aready, s1_bvalid;
  logic        r_bwe;
  logic [15:0] r_bdata;
  logic        m_avalid, m_awe;
  logic [23:0] m_aaddr;
  logic [15:0] m_adata;
  logic        m_aready = 1'b0;
  logic        m_bvalid = 1'b0, m_bwe = 1'b0;
  logic [15:0] m_bdata = '0;
  logic        err;

  sdram_arbiter #(.MAX_BURST(MB), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_avalid(s0_avalid), .s0_aready(s0_aready), .s0_awe(s0_awe), .s0_aaddr(s0_aaddr),
    .s0_adata(s0_adata), .s0_bvalid(s0_bvalid),
    .s1_avalid(s1_avalid), .s1_aready(s1_aready), .s1_awe(s1_awe), .s1_aaddr(s1_aaddr),
    .s1_adata(s1_adata), .s1_bvalid(s1_bvalid),
    .r_bwe(r_bwe), .r_bdata(r_bdata),
    .m_avalid(m_avalid), .m_aready(m_aready), .m_awe(m_awe), .m_aaddr(m_aaddr),
    .m_adata(m_adata), .m_bvalid(m_bvalid), .m_bwe(m_bwe), .m_bdata(m_bdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the bus, whose turn is next, and the ordered list of
  // ports still waiting for a response.
  bit          busy, owner, rr;
  int          cnt;
  logic [14:0] last;
  bit          tq[$];
  bit          e_bv0, e_bv1, e_bwe, e_err;
  logic [15:0] e_bdata;
  bit          sd_pend[$];   // sdram side: write flags of commands not yet answered

  int passes = 0, fails = 0, total = 0;
  int cyc = 0, acc0 = 0, acc1 = 0, bv0_seen = 0, bv1_seen = 0;
  int acc_cyc = 0, bv1_cyc = 0;
  bit acc_now0, acc_now1;
  int order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    acc0 = 0; acc1 = 0; bv0_seen = 0; bv1_seen = 0; cyc = 0;
    order.delete();
  endtask

  // One clock: predict, compare at the falling edge, advance the model, return at posedge+1.
  task automatic cycle();
    bit          v[2];
    bit          we[2];
    logic [23:0] a[2];
    bit          full, e_mav, acc, rel, h;
    bit          e_rdy0, e_rdy1;
    logic [14:0] key;
    v[0] = s0_avalid; v[1] = s1_avalid;
    we[0] = s0_awe;   we[1] = s1_awe;
    a[0] = s0_aaddr;  a[1] = s1_aaddr;
    full   = (tq.size() >= TD);
    e_rdy0 = busy && !owner && m_aready && !full;
    e_rdy1 = busy && owner && m_aready && !full;
    e_mav  = busy && v[owner] && !full;
    acc    = busy && v[owner] && m_aready && !full;
    @(negedge clk);
    chk("s0_aready", s0_aready, e_rdy0);
    chk("s1_aready", s1_aready, e_rdy1);
    chk("m_avalid", m_avalid, e_mav);
    if (e_mav) begin
      chk("m_aaddr", m_aaddr, a[owner]);
      chk("m_awe", m_awe, we[owner]);
      chk("m_adata", m_adata, owner ? s1_adata : s0_adata);
    end
    chk("s0_bvalid", s0_bvalid, e_bv0);
    chk("s1_bvalid", s1_bvalid, e_bv1);
    chk("err", err, e_err);
    if (e_bv0 || e_bv1) begin
      chk("r_bwe", r_bwe, e_bwe);
      chk("r_bdata", r_bdata, e_bdata);
    end
    acc_now0 = s0_avalid && s0_aready;
    acc_now1 = s1_avalid && s1_aready;
    if (acc_now0) begin acc0++; order.push_back(0); acc_cyc = cyc; end
    if (acc_now1) begin acc1++; order.push_back(1); acc_cyc = cyc; end
    if (s0_bvalid) bv0_seen++;
    if (s1_bvalid) begin bv1_seen++; bv1_cyc = cyc; end
    // responses
    e_bv0 = 0; e_bv1 = 0;
    if (m_bvalid) begin
      if (tq.size() > 0) begin
        h = tq.pop_front();
        e_bv0 = !h; e_bv1 = h; e_bwe = m_bwe; e_bdata = m_bdata;
      end else begin
        e_err = 1;
      end
    end
    // arbitration
    if (!busy) begin
      if ((v[0] || v[1]) && !full) begin
        busy = 1; owner = v[rr] ? rr : !rr; cnt = 0;
      end
    end else begin
      key = a[owner][23:9];
      rel = !v[owner] || (acc && cnt == MB - 1) || (v[!owner] && key != last && !acc);
      if (acc) begin
        tq.push_back(owner); sd_pend.push_back(we[owner]); last = key; cnt++;
      end
      if (rel) begin busy = 0; rr = !owner; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input bit keep_pend);
    @(posedge clk); #1;
    rst_n = 0; s0_avalid = 0; s1_avalid = 0; m_bvalid = 0; m_aready = 0;
    busy = 0; owner = 0; rr = 0; cnt = 0; last = '0; tq.delete();
    e_bv0 = 0; e_bv1 = 0; e_bwe = 0; e_bdata = '0; e_err = 0;
    if (!keep_pend) sd_pend.delete();
    #2;
    chk("rst_s0_aready", s0_aready, 0);
    chk("rst_s1_aready", s1_aready, 0);
    chk("rst_bvalid", {s0_bvalid, s1_bvalid}, 0);
    chk("rst_m_avalid", m_avalid, 0);
    chk("rst_r_bwe", r_bwe, 0);
    chk("rst_r_bdata", r_bdata, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    clr_counts();
  endtask

  task automatic respond(input int pct, input logic [15:0] rdata);
    if (sd_pend.size() > 0 && $urandom_range(99) < pct) begin
      m_bvalid = 1; m_bwe = sd_pend.pop_front(); m_bdata = rdata;
    end else begin
      m_bvalid = 0; m_bwe = 0; m_bdata = '0;
    end
  endtask

  task automatic req(input int p, input logic we, input logic [23:0] a, input logic [15:0] d);
    if (p == 0) begin s0_avalid = 1; s0_awe = we; s0_aaddr = a; s0_adata = d; end
    else        begin s1_avalid = 1; s1_awe = we; s1_aaddr = a; s1_adata = d; end
  endtask

  task automatic drop(input int p);
    if (p == 0) s0_avalid = 0; else s1_avalid = 0;
  endtask

  task automatic drain(input int n);
    drop(0); drop(1);
    for (int c = 0; c < n; c++) begin respond(100, 16'($urandom)); cycle(); end
    m_bvalid = 0;
  endtask

  initial begin
    int k, first_c, dly;
    bit seen;

    // Three writes from the capture port on one row.
    do_reset(0);
    m_aready = 1; k = 0; first_c = -1;
    req(0, 1, {13'h010, 2'b00, 9'd0}, 16'h1000);
    for (int c = 0; c < 20; c++) begin
      respond(100, 16'h0);
      cycle();
      if (acc_now0) begin
        if (first_c < 0) first_c = cyc - 1;
        k++;
        if (k < 3) req(0, 1, {13'h010, 2'b00, 9'(k)}, 16'h1000 + 16'(k)); else drop(0);
      end
    end
    chk("t1_acc0", acc0, 3);
    chk("t1_first_accept_cycle", first_c, 1);
    chk("t1_accept_span", acc_cyc - first_c, 2);
    chk("t1_bv0", bv0_seen, 3);
    chk("t1_bv1", bv1_seen, 0);

    // Both ports saturating the same row: alternating bursts of MB.
    do_reset(0);
    m_aready = 1;
    req(0, 1, {13'h020, 2'b01, 9'd0}, 16'hA000);
    req(1, 0, {13'h020, 2'b01, 9'd0}, 16'hB000);
    for (int c = 0; c < 60; c++) begin
      respond(100, 16'($urandom));
      cycle();
      if (acc_now0) req(0, 1, {13'h020, 2'b01, 9'($urandom)}, 16'($urandom));
      if (acc_now1) req(1, 0, {13'h020, 2'b01, 9'($urandom)}, 16'($urandom));
    end
    drain(10);
    for (int i = 0; i < 3 * MB; i++) chk("t2_burst_order", (i < order.size()) ? order[i] : 99, (i / MB) % 2);

    // Host read answered 4 cycles after acceptance.
    do_reset(0);
    m_aready = 1; dly = -1;
    req(1, 0, 24'h000123, 16'h0);
    for (int c = 0; c < 15; c++) begin
      if (dly == 4) respond(100, 16'hBEEF); else respond(0, 16'h0);
      if (dly >= 0) dly++;
      cycle();
      if (acc_now1) begin drop(1); dly = 1; end
    end
    chk("t3_bv1", bv1_seen, 1);
    chk("t3_bv0", bv0_seen, 0);
    chk("t3_resp_latency", bv1_cyc - acc_cyc, 5);
    chk("t3_rdata", r_bdata, 16'hBEEF);
    chk("t3_rbwe", r_bwe, 0);

    // Owner changes row while the host waits; sdram stalls that cycle so the owner yields.
    do_reset(0);
    m_aready = 1; seen = 0;
    req(0, 1, 24'h000200, 16'h1);
    req(1, 1, 24'h000300, 16'h2);
    for (int c = 0; c < 12; c++) begin
      respond(100, 16'h0);
      cycle();
      m_aready = 1;
      if (acc_now0 && !seen) begin req(0, 1, 24'h000A00, 16'h3); m_aready = 0; seen = 1; end
      else if (acc_now0) drop(0);
      if (acc_now1) drop(1);
    end
    drain(6);
    chk("t4_order_len", order.size(), 3);
    for (int i = 0; i < 3; i++) chk("t4_order", (i < order.size()) ? order[i] : 99, (i == 1) ? 1 : 0);

    // Responses withheld: tag queue caps outstanding commands.
    do_reset(0);
    m_aready = 1;
    req(0, 0, 24'h000400, 16'h0);
    for (int c = 0; c < 20; c++) begin
      respond(0, 16'h0); cycle();
      if (acc_now0) req(0, 0, 24'h000400 + 24'(acc0), 16'h0);
    end
    chk("t5_acc_at_full", acc0, TD);
    respond(100, 16'h1234); cycle();
    if (acc_now0) req(0, 0, 24'h000400 + 24'(acc0), 16'h0);
    for (int c = 0; c < 10; c++) begin
      respond(0, 16'h0); cycle();
      if (acc_now0) req(0, 0, 24'h000400 + 24'(acc0), 16'h0);
    end
    chk("t5_acc_after_one_resp", acc0, TD + 1);
    drain(20);

    // Random traffic against the model.
    do_reset(0);
    for (int c = 0; c < 1500; c++) begin
      m_aready = ($urandom_range(99) < 75);
      respond(40, 16'($urandom));
      cycle();
      if (acc_now0) drop(0);
      if (acc_now1) drop(1);
      if (!s0_avalid && $urandom_range(99) < 50)
        req(0, 1'($urandom), {13'($urandom_range(3)), 2'($urandom_range(1)), 9'($urandom)}, 16'($urandom));
      if (!s1_avalid && $urandom_range(99) < 50)
        req(1, 1'($urandom), {13'($urandom_range(3)), 2'($urandom_range(1)), 9'($urandom)}, 16'($urandom));
    end
    m_aready = 1;
    for (int c = 0; c < 40; c++) begin
      respond(100, 16'($urandom)); cycle();
      if (acc_now0) drop(0);
      if (acc_now1) drop(1);
    end
    drain(30);
    chk("t6_all_answered", tq.size(), 0);

    // Reset with three commands outstanding: late responses flag err only.
    do_reset(0);
    m_aready = 1;
    req(0, 1, 24'h000800, 16'h5);
    for (int c = 0; c < 8; c++) begin
      respond(0, 16'h0); cycle();
      if (acc_now0) begin if (acc0 < 3) req(0, 1, 24'h000800 + 24'(acc0), 16'h5); else drop(0); end
    end
    chk("t7_pending", sd_pend.size(), 3);
    do_reset(1);
    for (int c = 0; c < 8; c++) begin respond(100, 16'h7777); cycle(); end
    chk("t7_err", err, 1);
    chk("t7_bv", bv0_seen + bv1_seen, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
